ssp_pclk_evt_launch: RTL and testbench

PCLK-domain launcher for SSP events that must cross into the SSPCLK domain. These include TX FIFO write, RX FIFO read-pointer increment and interrupt/DMA clears. Each single-cycle PCLK event is converted into a registered, glitch-free 4-phase request level; the acknowledge returning from the SSPCLK domain is double-synchronised locally. Events arriving faster than the handshake can complete are queued in a per-channel saturating counter, and losses are flagged.

---
 rtl/ssp_pclk_evt_launch.sv | 111 +++++++++++
 tb/tb_ssp_pclk_evt_launch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_pclk_evt_launch.sv
// Purpose: PCLK-side launcher that turns single-cycle events into 4-phase request levels toward SSPCLK.
// Latency: an idle channel with nothing queued raises ReqOut on the edge that samples EvtIn; a loopback round trip takes 6 PCLK.
// Backpressure: events that arrive while a handshake is in flight are queued in a saturating counter; events beyond the limit are dropped and flagged.
module ssp_pclk_evt_launch #(
   parameter int NUM_EVT = 4,
   parameter int CNT_W   = 3
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic [NUM_EVT-1:0]         EvtIn,
   input  logic [NUM_EVT-1:0]         AckIn,
   output logic [NUM_EVT-1:0]         ReqOut,
   output logic [NUM_EVT*CNT_W-1:0]   Pending,
   output logic [NUM_EVT-1:0]         Overflow,
   input  logic [NUM_EVT-1:0]         OvfClr,
   output logic                       Busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RTZ  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NUM_EVT-1:0] chan_busy;

   for (genvar g = 0; g < NUM_EVT; g++) begin : g_chan
      logic             ack_sync1_q;
      logic             ack_sync_q;
      state_t           state_q, state_d;
      logic             req_q, req_d;
      logic [CNT_W-1:0] pend_q, pend_d;
      logic             ovf_q, ovf_d;
      logic             launch;
      logic             ovf_set;

      // Two-flop synchroniser for the acknowledge coming from SSPCLK
      always_ff @(posedge PCLK or negedge PRESETn) begin
         if (!PRESETn) begin
            ack_sync1_q <= 1'b0;
            ack_sync_q  <= 1'b0;
         end else begin
            ack_sync1_q <= AckIn[g];
            ack_sync_q  <= ack_sync1_q;
         end
      end

      // Handshake next state, queue counter and overflow flag
      always_comb begin
         state_d = state_q;
         pend_d  = pend_q;
         ovf_d   = ovf_q;
         launch  = 1'b0;
         ovf_set = 1'b0;

         // A new request may go out from IDLE, or straight from RTZ once the ack has returned to zero
         launch = ((state_q == ST_IDLE) || ((state_q == ST_RTZ) && !ack_sync_q)) &&
                  ((pend_q != '0) || EvtIn[g]);

         case (state_q)
            ST_IDLE: if (launch) state_d = ST_REQ;
            ST_REQ:  if (ack_sync_q) state_d = ST_RTZ;
            ST_RTZ: begin
               if (launch)           state_d = ST_REQ;
               else if (!ack_sync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         // Event with launch bypasses the queue; launch alone drains one queued event
         if (EvtIn[g] && !launch) begin
            if (pend_q == CNT_MAX) ovf_set = 1'b1;
            else                   pend_d  = pend_q + CNT_ONE;
         end else if (!EvtIn[g] && launch) begin
            pend_d = pend_q - CNT_ONE;
         end

         // A loss in the same cycle as a clear must not be hidden
         if (ovf_set)        ovf_d = 1'b1;
         else if (OvfClr[g]) ovf_d = 1'b0;

         req_d = (state_d == ST_REQ);
      end

      // Channel state registers; ReqOut comes straight from req_q
      always_ff @(posedge PCLK or negedge PRESETn) begin
         if (!PRESETn) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
         end
      end

      assign ReqOut[g]                  = req_q;
      assign Pending[g*CNT_W +: CNT_W]  = pend_q;
      assign Overflow[g]                = ovf_q;
      assign chan_busy[g]               = (state_q != ST_IDLE) || (pend_q != '0);
   end

   assign Busy = |chan_busy;

endmodule

// File: tb/tb_ssp_pclk_evt_launch.sv
// Purpose: directed self-checking bench for ssp_pclk_evt_launch (4 channels, 2-bit counters).
// Latency: inputs change on the falling edge, outputs are checked on the falling edge after each rising edge.
// Backpressure: per-channel AckIn is either looped back from ReqOut or held by the bench.
module tb_ssp_pclk_evt_launch;
   localparam int NUM_EVT = 4;
   localparam int CNT_W   = 2;

   logic                     PCLK;
   logic                     PRESETn;
   logic [NUM_EVT-1:0]       EvtIn;
   logic [NUM_EVT-1:0]       AckIn;
   logic [NUM_EVT-1:0]       ReqOut;
   logic [NUM_EVT*CNT_W-1:0] Pending;
   logic [NUM_EVT-1:0]       Overflow;
   logic [NUM_EVT-1:0]       OvfClr;
   logic                     Busy;

   logic [NUM_EVT-1:0] lb_en;
   logic [NUM_EVT-1:0] ack_man;
   logic [NUM_EVT-1:0] prev_req;
   int                 rise_cnt [NUM_EVT];
   int                 tests_run;
   int                 tests_failed;

   assign AckIn = (lb_en & ReqOut) | (~lb_en & ack_man);

   ssp_pclk_evt_launch #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .EvtIn    (EvtIn),
      .AckIn    (AckIn),
      .ReqOut   (ReqOut),
      .Pending  (Pending),
      .Overflow (Overflow),
      .OvfClr   (OvfClr),
      .Busy     (Busy)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   function automatic logic [CNT_W-1:0] pend(input int ch);
      return Pending[ch*CNT_W +: CNT_W];
   endfunction

   // Advance across one rising edge and land on the following falling edge
   task automatic step();
      @(posedge PCLK);
      @(negedge PCLK);
      for (int c = 0; c < NUM_EVT; c++) begin
         if (ReqOut[c] && !prev_req[c]) rise_cnt[c]++;
      end
      prev_req = ReqOut;
   endtask

   task automatic clear_rises();
      for (int c = 0; c < NUM_EVT; c++) rise_cnt[c] = 0;
      prev_req = ReqOut;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      EvtIn   = '0;
      OvfClr  = '0;
      lb_en   = '1;
      ack_man = '0;
      prev_req = '0;
      #23;
      tests_run++;
      if (ReqOut !== 4'b0000) begin tests_failed++; $display("FAIL reset_req got %b want 0000", ReqOut); end
      tests_run++;
      if (Pending !== 8'h00) begin tests_failed++; $display("FAIL reset_pending got %h want 00", Pending); end
      tests_run++;
      if (Overflow !== 4'b0000) begin tests_failed++; $display("FAIL reset_ovf got %b want 0000", Overflow); end
      tests_run++;
      if (Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", Busy); end
      @(negedge PCLK);
      PRESETn = 1'b1;
      step();
      clear_rises();
   endtask

   // One event on channel 0 with loopback: ReqOut high after edges 0..2, idle after edge 6
   task automatic test_single();
      logic exp_req, exp_busy;
      EvtIn[0] = 1'b1;
      for (int e = 0; e < 8; e++) begin
         step();
         EvtIn[0] = 1'b0;
         exp_req  = (e < 3);
         exp_busy = (e < 6);
         tests_run++;
         if (ReqOut[0] !== exp_req) begin tests_failed++; $display("FAIL single_req edge %0d got %b want %b", e, ReqOut[0], exp_req); end
         tests_run++;
         if (Busy !== exp_busy) begin tests_failed++; $display("FAIL single_busy edge %0d got %b want %b", e, Busy, exp_busy); end
         tests_run++;
         if (pend(0) !== 2'd0) begin tests_failed++; $display("FAIL single_pending edge %0d got %0d want 0", e, pend(0)); end
      end
      tests_run++;
      if (rise_cnt[0] !== 1) begin tests_failed++; $display("FAIL single_rises got %0d want 1", rise_cnt[0]); end
      clear_rises();
   endtask

   // Three back-to-back events on channel 1: requests rise after edges 0, 6, 12
   task automatic test_back_to_back();
      logic [CNT_W-1:0] exp_p;
      logic             rose;
      logic             exp_rose;
      for (int e = 0; e < 20; e++) begin
         EvtIn[1] = (e < 3);
         step();
         rose     = ReqOut[1] && (rise_cnt[1] > 0) && (e == 0 || e == 6 || e == 12);
         exp_rose = (e == 0 || e == 6 || e == 12);
         if (exp_rose) begin
            tests_run++;
            if (!rose || ReqOut[1] !== 1'b1) begin tests_failed++; $display("FAIL burst_rise edge %0d got req %b want 1", e, ReqOut[1]); end
         end
         case (e)
            1: exp_p = 2'd1;
            2, 3, 4, 5: exp_p = 2'd2;
            6, 7, 8, 9, 10, 11: exp_p = 2'd1;
            default: exp_p = 2'd0;
         endcase
         tests_run++;
         if (pend(1) !== exp_p) begin tests_failed++; $display("FAIL burst_pending edge %0d got %0d want %0d", e, pend(1), exp_p); end
         if (e == 5 || e == 11) begin
            tests_run++;
            if (ReqOut[1] !== 1'b0) begin tests_failed++; $display("FAIL burst_rtz edge %0d got %b want 0", e, ReqOut[1]); end
         end
      end
      tests_run++;
      if (rise_cnt[1] !== 3) begin tests_failed++; $display("FAIL burst_rises got %0d want 3", rise_cnt[1]); end
      tests_run++;
      if (Busy !== 1'b0) begin tests_failed++; $display("FAIL burst_busy_end got %b want 0", Busy); end
      EvtIn[1] = 1'b0;
      clear_rises();
   endtask

   // Channel 2 with ack held low: five events saturate the 2-bit queue, then the clear priority is exercised
   task automatic test_saturation();
      lb_en[2]   = 1'b0;
      ack_man[2] = 1'b0;
      for (int e = 0; e < 5; e++) begin
         EvtIn[2] = 1'b1;
         step();
      end
      EvtIn[2] = 1'b0;
      tests_run++;
      if (pend(2) !== 2'd3) begin tests_failed++; $display("FAIL sat_pending got %0d want 3", pend(2)); end
      tests_run++;
      if (Overflow[2] !== 1'b1) begin tests_failed++; $display("FAIL sat_ovf got %b want 1", Overflow[2]); end
      tests_run++;
      if (ReqOut[2] !== 1'b1) begin tests_failed++; $display("FAIL sat_req got %b want 1", ReqOut[2]); end
      step();
      tests_run++;
      if (Overflow[2] !== 1'b1) begin tests_failed++; $display("FAIL sat_ovf_sticky got %b want 1", Overflow[2]); end

      EvtIn[2]  = 1'b1;
      OvfClr[2] = 1'b1;
      step();
      EvtIn[2]  = 1'b0;
      tests_run++;
      if (Overflow[2] !== 1'b1) begin tests_failed++; $display("FAIL ovf_set_priority got %b want 1", Overflow[2]); end
      tests_run++;
      if (pend(2) !== 2'd3) begin tests_failed++; $display("FAIL ovf_pending_hold got %0d want 3", pend(2)); end
      step();
      OvfClr[2] = 1'b0;
      tests_run++;
      if (Overflow[2] !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", Overflow[2]); end

      lb_en[2] = 1'b1;
      for (int e = 0; e < 30; e++) step();
      tests_run++;
      if (rise_cnt[2] !== 4) begin tests_failed++; $display("FAIL sat_total_pulses got %0d want 4", rise_cnt[2]); end
      tests_run++;
      if (pend(2) !== 2'd0 || Busy !== 1'b0) begin tests_failed++; $display("FAIL sat_drain got pending %0d busy %b want 0 0", pend(2), Busy); end
      clear_rises();
   endtask

   // Reset asserted while channel 0 sits in REQ with two events queued
   task automatic test_reset_mid();
      lb_en[0]   = 1'b0;
      ack_man[0] = 1'b0;
      for (int e = 0; e < 3; e++) begin
         EvtIn[0] = 1'b1;
         step();
      end
      EvtIn[0] = 1'b0;
      tests_run++;
      if (pend(0) !== 2'd2 || ReqOut[0] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_setup got pending %0d req %b want 2 1", pend(0), ReqOut[0]); end
      #2;
      PRESETn = 1'b0;
      #1;
      tests_run++;
      if (ReqOut !== 4'b0000 || Pending !== 8'h00 || Overflow !== 4'b0000 || Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_async got req %b pend %h ovf %b busy %b want all 0", ReqOut, Pending, Overflow, Busy);
      end
      @(negedge PCLK);
      PRESETn  = 1'b1;
      lb_en[0] = 1'b1;
      clear_rises();
      for (int e = 0; e < 10; e++) step();
      tests_run++;
      if (rise_cnt[0] !== 0 || Busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_quiet got rises %0d busy %b want 0 0", rise_cnt[0], Busy); end
      EvtIn[0] = 1'b1;
      step();
      EvtIn[0] = 1'b0;
      tests_run++;
      if (ReqOut[0] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_new_evt got %b want 1", ReqOut[0]); end
      for (int e = 0; e < 8; e++) step();
      clear_rises();
   endtask

   // Channels 0 and 3 fire together; channel 3's ack is held off for ten cycles
   task automatic test_independence();
      logic exp_busy;
      lb_en[3]   = 1'b0;
      ack_man[3] = 1'b0;
      EvtIn      = 4'b1001;
      for (int e = 0; e < 17; e++) begin
         step();
         EvtIn = '0;
         if (e == 9) lb_en[3] = 1'b1;
         if (e <= 3) begin
            tests_run++;
            if (ReqOut[0] !== (e < 3)) begin tests_failed++; $display("FAIL indep_ch0 edge %0d got %b want %b", e, ReqOut[0], (e < 3)); end
         end
         if (e == 11 || e == 12) begin
            tests_run++;
            if (ReqOut[3] !== (e == 11)) begin tests_failed++; $display("FAIL indep_ch3 edge %0d got %b want %b", e, ReqOut[3], (e == 11)); end
         end
         exp_busy = (e < 15);
         tests_run++;
         if (Busy !== exp_busy) begin tests_failed++; $display("FAIL indep_busy edge %0d got %b want %b", e, Busy, exp_busy); end
      end
      tests_run++;
      if (rise_cnt[0] !== 1 || rise_cnt[3] !== 1) begin tests_failed++; $display("FAIL indep_rises got %0d %0d want 1 1", rise_cnt[0], rise_cnt[3]); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      for (int c = 0; c < NUM_EVT; c++) rise_cnt[c] = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      test_independence();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
